// File: rtl/mult_issue_ctrl_if.sv
// Handshake bundle for mult_issue_ctrl: request port, multiplier drive/return, and response port.
// The slave modport is the controller's view; master is the surrounding environment.
interface mult_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_mlier;
    logic [31:0]       req_mcand;
    logic [TAG_W-1:0]  req_tag;

    logic              mul_start;
    logic [31:0]       mul_mlier;
    logic [31:0]       mul_mcand;
    logic              mul_valid;
    logic [63:0]       mul_prodt;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_prodt;
    logic [TAG_W-1:0]  rsp_tag;

    modport slave (
        input  req_valid, req_mlier, req_mcand, req_tag,
        output req_ready,
        output mul_start, mul_mlier, mul_mcand,
        input  mul_valid, mul_prodt,
        output rsp_valid, rsp_prodt, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_mlier, req_mcand, req_tag,
        input  req_ready,
        input  mul_start, mul_mlier, mul_mcand,
        output mul_valid, mul_prodt,
        input  rsp_valid, rsp_prodt, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue stage for the 32x32 signed shift/add multiplier: request FIFO, start/operand driver, tagged response.
// Optional macro MULT_ISSUE_ZERO_BYPASS_EN answers zero-operand requests directly without issuing them.
module mult_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int TAG_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                clock,
    input  logic                reset,
    mult_issue_ctrl_if.slave    bus,
    output logic                busy,
    output logic [AW:0]         count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    logic [TAG_W+63:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              req_ready;
    logic              push;
    logic              pop;
    logic              slot_free;
    logic [TAG_W+63:0] head;
    logic [TAG_W-1:0]  head_tag;
    logic [31:0]       head_mlier;
    logic [31:0]       head_mcand;
    logic              head_zero;

    logic [1:0]        state;
    logic [SW-1:0]     settle_cnt;
    logic              mul_start;
    logic [31:0]       mul_mlier;
    logic [31:0]       mul_mcand;
    logic [TAG_W-1:0]  run_tag;
    logic              rsp_valid;
    logic [63:0]       rsp_prodt;
    logic [TAG_W-1:0]  rsp_tag;

    assign req_ready  = (count != (AW+1)'(DEPTH));
    assign push       = bus.req_valid && req_ready;
    assign slot_free  = !rsp_valid || bus.rsp_ready;
    assign pop        = (state == ST_IDLE) && (count != '0) && slot_free;

    assign head       = mem[rd_ptr];
    assign head_tag   = head[TAG_W+63:64];
    assign head_mlier = head[63:32];
    assign head_mcand = head[31:0];

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    assign head_zero  = (head_mlier == 32'd0) || (head_mcand == 32'd0);
`else
    assign head_zero  = 1'b0;
`endif

    assign bus.req_ready = req_ready;
    assign bus.mul_start = mul_start;
    assign bus.mul_mlier = mul_mlier;
    assign bus.mul_mcand = mul_mcand;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_prodt = rsp_prodt;
    assign bus.rsp_tag   = rsp_tag;

    assign busy = (state != ST_IDLE) || (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_tag, bus.req_mlier, bus.req_mcand};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A response leaves on rsp_ready; a new one is only produced once the slot is free,
    // so the clear below never collides with a capture of a different result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            mul_start  <= 1'b0;
            mul_mlier  <= '0;
            mul_mcand  <= '0;
            run_tag    <= '0;
            rsp_valid  <= 1'b0;
            rsp_prodt  <= '0;
            rsp_tag    <= '0;
        end else begin
            if (rsp_valid && bus.rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head_zero) begin
                            rsp_valid <= 1'b1;
                            rsp_prodt <= '0;
                            rsp_tag   <= head_tag;
                        end else begin
                            mul_mlier <= head_mlier;
                            mul_mcand <= head_mcand;
                            run_tag   <= head_tag;
                            mul_start <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.mul_valid) begin
                        settle_cnt <= SW'(SETTLE);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Capture on the edge where the counter steps down to zero.
                    if (settle_cnt <= SW'(1)) begin
                        settle_cnt <= '0;
                        rsp_prodt  <= bus.mul_prodt;
                        rsp_tag    <= run_tag;
                        rsp_valid  <= 1'b1;
                        mul_start  <= 1'b0;
                        state      <= ST_GAP;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural level-sensitive multiplier model.
// Build with or without MULT_ISSUE_ZERO_BYPASS_EN; the zero-operand scenario follows the macro.
module tb_mult_issue_ctrl;

    logic       clock;
    logic       reset;
    logic       busy;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    mult_issue_ctrl_if #(.TAG_W(4)) bus ();

    mult_issue_ctrl #(.DEPTH(4), .AW(2), .TAG_W(4), .SETTLE(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .count (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier model: valid rises a few cycles after start, product registered one cycle after valid.
    int                 mcyc;
    logic               mvalid;
    logic [63:0]        mprodt;
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    assign ext_a = {{32{bus.mul_mlier[31]}}, bus.mul_mlier};
    assign ext_b = {{32{bus.mul_mcand[31]}}, bus.mul_mcand};
    assign bus.mul_valid = mvalid;
    assign bus.mul_prodt = mprodt;

    always @(posedge clock) begin
        if (!bus.mul_start) begin
            mcyc   <= 0;
            mvalid <= 1'b0;
            mprodt <= 64'hDEADBEEF_CAFEF00D;
        end else begin
            mcyc <= mcyc + 1;
            if (mcyc == 4) mvalid <= 1'b1;
            if (mvalid) mprodt <= ext_a * ext_b;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("[TB] FAIL push_timeout: req_ready got %0b required 1 (tag %0d)", bus.req_ready, t);
        end
        bus.req_valid = 1'b1;
        bus.req_mlier = a;
        bus.req_mcand = b;
        bus.req_tag   = t;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic ok);
        int n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        ok = bus.rsp_valid;
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL rsp_timeout: rsp_valid got 0 required 1");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_mlier = 32'd1;
        bus.req_mcand = 32'd1;
        bus.req_tag   = 4'd1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.mul_start, bus.mul_mlier, bus.mul_mcand, bus.rsp_valid, bus.rsp_prodt,
                 bus.rsp_tag, busy, count} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: start=%0b mlier=%0h mcand=%0h rv=%0b prodt=%0h tag=%0h busy=%0b count=%0d required all 0",
                         bus.mul_start, bus.mul_mlier, bus.mul_mcand, bus.rsp_valid, bus.rsp_prodt,
                         bus.rsp_tag, busy, count);
            end
        end
        reset = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if ({bus.req_ready, count, busy} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release: req_ready=%0b count=%0d busy=%0b required 1/0/0",
                     bus.req_ready, count, busy);
        end
    endtask

    task automatic test_basic();
        logic ok;
        int   n;
        int   vcyc;
        int   started;
        int   low;
        int   gap;
        int   nr;
        logic [63:0] got_p [2];
        logic [3:0]  got_t [2];
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_mlier = 32'd3;
        bus.req_mcand = 32'd5;
        bus.req_tag   = 4'd1;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || bus.mul_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_edge: count=%0d start=%0b required 1/0", count, bus.mul_start);
        end
        tick();
        checks++;
        if ({bus.mul_start, count, bus.mul_mlier, bus.mul_mcand, busy} !==
            {1'b1, 3'd0, 32'd3, 32'd5, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pop_edge: start=%0b count=%0d mlier=%0h mcand=%0h busy=%0b required 1/0/3/5/1",
                     bus.mul_start, count, bus.mul_mlier, bus.mul_mcand, busy);
        end
        n = 0;
        while (!bus.mul_valid && n < 100) begin
            tick();
            n++;
        end
        vcyc = cyc;
        wait_rsp(ok);
        checks++;
        if (cyc - vcyc != 2) begin
            errors++;
            $display("[TB] FAIL rsp_latency: got %0d edges after mul_valid required 2", cyc - vcyc);
        end
        checks++;
        if (bus.rsp_prodt !== 64'd15 || bus.rsp_tag !== 4'd1) begin
            errors++;
            $display("[TB] FAIL basic_3x5: prodt=%0h tag=%0d required 15/1", bus.rsp_prodt, bus.rsp_tag);
        end
        tick();
        push_req(32'd2, 32'd2, 4'd2);
        push_req(32'hFFFFFFFF, 32'd4, 4'd3);
        started = 0; low = 0; gap = -1; nr = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.rsp_valid && nr < 2) begin
                got_p[nr] = bus.rsp_prodt;
                got_t[nr] = bus.rsp_tag;
                nr++;
            end
            if (bus.mul_start) begin
                if (started != 0 && low > 0 && gap < 0) gap = low;
                started = 1;
                low = 0;
            end else if (started != 0) begin
                low++;
            end
            tick();
        end
        checks++;
        if (gap < 1) begin
            errors++;
            $display("[TB] FAIL start_gap: low cycles between issues got %0d required >=1", gap);
        end
        checks++;
        if (nr != 2) begin
            errors++;
            $display("[TB] FAIL gap_rsp_count: got %0d responses required 2", nr);
        end else begin
            checks++;
            if (got_p[0] !== 64'd4 || got_t[0] !== 4'd2) begin
                errors++;
                $display("[TB] FAIL gap_rsp0: prodt=%0h tag=%0d required 4/2", got_p[0], got_t[0]);
            end
            checks++;
            if (got_p[1] !== 64'hFFFFFFFFFFFFFFFC || got_t[1] !== 4'd3) begin
                errors++;
                $display("[TB] FAIL gap_rsp1: prodt=%0h tag=%0d required fffffffffffffffc/3", got_p[1], got_t[1]);
            end
        end
    endtask

    task automatic test_signed();
        logic ok;
        bus.rsp_ready = 1'b1;
        push_req(32'hFFFFFFF9, 32'd6, 4'd3);
        wait_rsp(ok);
        checks++;
        if (bus.rsp_prodt !== 64'hFFFFFFFFFFFFFFD6 || bus.rsp_tag !== 4'd3) begin
            errors++;
            $display("[TB] FAIL signed_m7x6: prodt=%0h tag=%0d required ffffffffffffffd6/3", bus.rsp_prodt, bus.rsp_tag);
        end
        tick();
        push_req(32'h80000000, 32'h80000000, 4'd4);
        wait_rsp(ok);
        checks++;
        if (bus.rsp_prodt !== 64'h4000000000000000 || bus.rsp_tag !== 4'd4) begin
            errors++;
            $display("[TB] FAIL signed_min_sq: prodt=%0h tag=%0d required 4000000000000000/4", bus.rsp_prodt, bus.rsp_tag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        ok;
        logic        held;
        logic [63:0] exp_p [6];
        exp_p = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60};
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push_req(32'(t + 1), 32'd10, 4'(t));
        end
        wait_rsp(ok);
        checks++;
        if (bus.rsp_prodt !== 64'd10 || bus.rsp_tag !== 4'd0) begin
            errors++;
            $display("[TB] FAIL b2b_first: prodt=%0h tag=%0d required 10/0", bus.rsp_prodt, bus.rsp_tag);
        end
        held = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd0 || bus.rsp_prodt !== 64'd10) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL rsp_hold: valid=%0b tag=%0d prodt=%0h required 1/0/10 held",
                     bus.rsp_valid, bus.rsp_tag, bus.rsp_prodt);
        end
        checks++;
        if (count !== 3'd4 || bus.req_ready !== 1'b0 || bus.mul_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifo_full: count=%0d req_ready=%0b start=%0b required 4/0/0",
                     count, bus.req_ready, bus.mul_start);
        end
        bus.rsp_ready = 1'b1;
        fork
            begin
                push_req(32'd6, 32'd10, 4'd5);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    int n = 0;
                    while (!bus.rsp_valid && n < 100) begin
                        tick();
                        n++;
                    end
                    checks++;
                    if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(k) || bus.rsp_prodt !== exp_p[k]) begin
                        errors++;
                        $display("[TB] FAIL b2b_order_%0d: valid=%0b tag=%0d prodt=%0h required 1/%0d/%0h",
                                 k, bus.rsp_valid, bus.rsp_tag, bus.rsp_prodt, k, exp_p[k]);
                    end
                    tick();
                end
            end
        join
    endtask

    task automatic test_reset_mid_run();
        logic ok;
        logic rose;
        int   n;
        bus.rsp_ready = 1'b1;
        push_req(32'd7, 32'd7, 4'd9);
        push_req(32'd2, 32'd2, 4'd11);
        n = 0;
        while (!bus.mul_start && n < 20) begin
            tick();
            n++;
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (bus.mul_start !== 1'b0 || count !== 3'd0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort: start=%0b count=%0d rv=%0b busy=%0b required 0/0/0/0",
                     bus.mul_start, count, bus.rsp_valid, busy);
        end
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rsp_valid) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("[TB] FAIL reset_no_rsp: rsp_valid got 1 required 0 after abort");
        end
        push_req(32'd2, 32'd3, 4'd10);
        wait_rsp(ok);
        checks++;
        if (bus.rsp_prodt !== 64'd6 || bus.rsp_tag !== 4'd10) begin
            errors++;
            $display("[TB] FAIL post_reset_op: prodt=%0h tag=%0d required 6/10", bus.rsp_prodt, bus.rsp_tag);
        end
        tick();
    endtask

    task automatic test_zero();
        bus.rsp_ready = 1'b1;
        push_req(32'd0, 32'd9, 4'd12);
        tick();
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
        checks++;
        if (bus.mul_start !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_prodt !== 64'd0 || bus.rsp_tag !== 4'd12) begin
            errors++;
            $display("[TB] FAIL zero_bypass: start=%0b rv=%0b prodt=%0h tag=%0d required 0/1/0/12",
                     bus.mul_start, bus.rsp_valid, bus.rsp_prodt, bus.rsp_tag);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || bus.mul_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_idle: busy=%0b start=%0b required 0/0", busy, bus.mul_start);
        end
`else
        begin
            logic ok;
            checks++;
            if (bus.mul_start !== 1'b1) begin
                errors++;
                $display("[TB] FAIL zero_issue: start=%0b required 1", bus.mul_start);
            end
            wait_rsp(ok);
            checks++;
            if (bus.rsp_prodt !== 64'd0 || bus.rsp_tag !== 4'd12) begin
                errors++;
                $display("[TB] FAIL zero_normal: prodt=%0h tag=%0d required 0/12", bus.rsp_prodt, bus.rsp_tag);
            end
            tick();
        end
`endif
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mlier = '0;
        bus.req_mcand = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
